idex_stage: RTL

Parametrised decode/execute pipeline stage for the SIMD multimedia unit, replacing the free-running ID/EX latch. It registers the decoded function field and NUM_OPS operand vectors of DATA_W bits. It adds a valid/ready handshake with a two-entry skid buffer so the execute stage can stall without a combinational ready path back into decode. It also provides a synchronous pipeline flush and a saturating stall-cycle counter for performance monitoring.

---
 rtl/idex_pkg.sv | 13 +
 rtl/pipe_skid_buf.sv | 81 ++++++++
 rtl/idex_stage.sv | 70 +++++++
 3 files changed

// File: rtl/idex_pkg.sv
// Shared constants and payload sizing for the SIMD decode/execute stage.
package idex_pkg;

   localparam int IDEX_INSTR_W = 25;
   localparam int IDEX_DATA_W  = 128;
   localparam int IDEX_NUM_OPS = 3;
   localparam int IDEX_CNT_W   = 16;

   function automatic int idex_payload_w(input int instr_w, input int data_w, input int num_ops);
      return instr_w + num_ops * data_w;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush; in_ready
// depends only on registered state and flush, never on out_ready.
module pipe_skid_buf
   import idex_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_data_q,  main_data_d;
   logic [W-1:0] skid_data_q,  skid_data_d;

   logic in_fire;
   logic out_fire;
   logic main_load;

   assign in_ready  = !skid_valid_q && !flush;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid_q && out_ready;
   assign main_load = !main_valid_q || out_fire;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;

      if (main_load) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_data_d = in_data;
         end
         main_valid_d = skid_valid_q || in_fire;
      end else if (in_fire) begin
         skid_data_d  = in_data;
         skid_valid_d = 1'b1;
      end

      // Payload is left stale on flush; only the valid bits matter.
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   // NOTE: payload registers are reset too, because zero outputs are required straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments only in clocked blocks, so every flop samples pre-edge values.
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/idex_stage.sv
// Decode/execute pipeline stage: packs {func, ops} through a skid buffer and
// counts execute-side stall cycles with a saturating counter.
module idex_stage
   import idex_pkg::*;
#(
   parameter int INSTR_W = IDEX_INSTR_W,
   parameter int DATA_W  = IDEX_DATA_W,
   parameter int NUM_OPS = IDEX_NUM_OPS,
   parameter int CNT_W   = IDEX_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSTR_W-1:0]        in_func,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [INSTR_W-1:0]        out_func,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [1:0]                occupancy,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam int PAYLOAD_W = idex_payload_w(INSTR_W, DATA_W, NUM_OPS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAYLOAD_W-1:0] in_payload;
   logic [PAYLOAD_W-1:0] out_payload;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

   assign in_payload = {in_func, in_ops};

   pipe_skid_buf #(
      .W(PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload),
      .occupancy (occupancy)
   );

   assign out_func = out_payload[PAYLOAD_W-1 -: INSTR_W];
   assign out_ops  = out_payload[NUM_OPS*DATA_W-1:0];

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
